// File: rtl/issue_scheduler_pkg.sv
// Shared types for the issue scheduler: one CDB broadcast slot and helpers.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package issue_scheduler_pkg;
  import sys_defs::*;

  // Width of the source-FU field in a slot; matches RS_IDX_W of the default
  // four-station configuration.
  localparam int SLOT_SRC_W = 2;

  // One reserved CDB cycle: whether it is taken, the tag woken up, and the
  // reservation station whose FU produces the value.
  typedef struct packed {
    logic                   valid;
    logic [ROB_TAG_LEN-1:0] tag;
    logic [SLOT_SRC_W-1:0]  src;
  } CDB_SLOT;

  // Modular add used for walking requesters in round-robin order.
  function automatic int wrap_add(input int a, input int b, input int n);
    return (a + b) % n;
  endfunction
endpackage

// File: rtl/sys_defs.sv
// System-wide definitions shared across the out-of-order core.
// ROB_TAG_LEN: width of a reorder-buffer tag carried on the CDB.
// No logic, only constants.
package sys_defs;
  localparam int ROB_TAG_LEN = 6;
endpackage

// File: rtl/issue_scheduler_if.sv
// Issue/wakeup bundle between the reservation stations and the scheduler.
// Latency: rs_issue combinational from rs_ready; cdb_* registered.
// Backpressure: an RS holds rs_ready until it sees rs_issue; no other stall.
// Signals: rs_ready/rs_dst_tag/flush from the RS side, rs_issue/cdb_* back.
interface issue_scheduler_if #(
  parameter int NUM_RS   = 4,
  parameter int RS_IDX_W = 2
);
  import sys_defs::*;

  logic [NUM_RS-1:0]             rs_ready;
  logic [NUM_RS*ROB_TAG_LEN-1:0] rs_dst_tag;
  logic                          flush;
  logic [NUM_RS-1:0]             rs_issue;
  logic                          cdb_valid;
  logic [ROB_TAG_LEN-1:0]        cdb_tag;
  logic [RS_IDX_W-1:0]           cdb_src;

  // Scheduler side.
  modport master (
    input  rs_ready, rs_dst_tag, flush,
    output rs_issue, cdb_valid, cdb_tag, cdb_src
  );

  // Reservation-station side.
  modport slave (
    output rs_ready, rs_dst_tag, flush,
    input  rs_issue, cdb_valid, cdb_tag, cdb_src
  );
endinterface

// File: rtl/issue_rr_select.sv
// Round-robin grant selection over eligible stations with per-cycle slot claims.
// Latency: purely combinational.
// Backpressure: a station losing its slot to an earlier one in RR order is simply not granted.
// Ports: rr_ptr (start of scan), eligible, rs_lat (packed per-RS latency)
//        -> grant vector, next_ptr (one past last grant, or rr_ptr if none).
module issue_rr_select
  import issue_scheduler_pkg::*;
#(
  parameter int NUM_RS   = 4,
  parameter int RS_IDX_W = 2,
  parameter int MAX_LAT  = 4,
  parameter int LAT_W    = 3
) (
  input  logic [RS_IDX_W-1:0]     rr_ptr,
  input  logic [NUM_RS-1:0]       eligible,
  input  logic [NUM_RS*LAT_W-1:0] rs_lat,
  output logic [NUM_RS-1:0]       grant,
  output logic [RS_IDX_W-1:0]     next_ptr
);

  // claimed[L] marks the CDB cycle now+L as taken by a grant made earlier
  // in this same scan.
  logic [MAX_LAT:0] claimed;

  always_comb begin
    int idx;
    int lat;
    claimed  = '0;
    grant    = '0;
    next_ptr = rr_ptr;
    idx      = 0;
    lat      = 0;
    for (int i = 0; i < NUM_RS; i++) begin
      idx = wrap_add(int'(rr_ptr), i, NUM_RS);
      lat = int'(rs_lat[idx*LAT_W +: LAT_W]);
      if (eligible[idx] && !claimed[lat]) begin
        grant[idx]   = 1'b1;
        claimed[lat] = 1'b1;
        // Later grants in scan order overwrite, leaving one past the last.
        next_ptr     = RS_IDX_W'(wrap_add(idx, 1, NUM_RS));
      end
    end
  end

endmodule

// File: rtl/issue_scheduler.sv
// Issue scheduler: picks ready RSs so their fixed-latency results never collide on the CDB.
// Latency: rs_issue combinational; wakeup on cdb_* exactly RS latency cycles after grant.
// Backpressure: a requester whose CDB cycle is taken is stalled (rs_issue low) and retries.
// Ports: clk, reset_n (async active-low), bus (issue_scheduler_if.master:
//        rs_ready, rs_dst_tag, flush in; rs_issue, cdb_valid, cdb_tag, cdb_src out).
// Optional: define ISSUE_SCHED_PERF_EN to add the 32-bit perf_stall_cnt output.
module issue_scheduler
  import sys_defs::*;
  import issue_scheduler_pkg::*;
#(
  parameter int                    NUM_RS   = 4,
  parameter int                    RS_IDX_W = 2,
  parameter int                    MAX_LAT  = 4,
  parameter int                    LAT_W    = 3,
  parameter logic [NUM_RS*LAT_W-1:0] RS_LAT = {3'd4, 3'd1, 3'd1, 3'd1}
) (
  input  logic               clk,
  input  logic               reset_n,
  issue_scheduler_if.master  bus
`ifdef ISSUE_SCHED_PERF_EN
  ,
  output logic [31:0]        perf_stall_cnt
`endif
);

  // slots[j] is the CDB broadcast reserved for cycle now+j.
  CDB_SLOT             slots [MAX_LAT];
  logic [RS_IDX_W-1:0] rr_ptr;
  logic [RS_IDX_W-1:0] next_ptr;
  logic [NUM_RS-1:0]   eligible;
  logic [NUM_RS-1:0]   grant;
  // Occupancy of cycles now..now+MAX_LAT; the top entry is always free since
  // nothing can have been reserved that far ahead yet.
  logic [MAX_LAT:0]    slot_busy;

  always_comb begin
    slot_busy = '0;
    for (int j = 0; j < MAX_LAT; j++) begin
      slot_busy[j] = slots[j].valid;
    end
  end

  always_comb begin
    eligible = '0;
    for (int k = 0; k < NUM_RS; k++) begin
      eligible[k] = bus.rs_ready[k]
                 && !slot_busy[int'(RS_LAT[k*LAT_W +: LAT_W])]
                 && !bus.flush;
    end
  end

  issue_rr_select #(
    .NUM_RS   (NUM_RS),
    .RS_IDX_W (RS_IDX_W),
    .MAX_LAT  (MAX_LAT),
    .LAT_W    (LAT_W)
  ) u_rr_select (
    .rr_ptr   (rr_ptr),
    .eligible (eligible),
    .rs_lat   (RS_LAT),
    .grant    (grant),
    .next_ptr (next_ptr)
  );

  // Gate with reset so no strobe escapes while the table is being cleared.
  assign bus.rs_issue = grant & {NUM_RS{reset_n}};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int j = 0; j < MAX_LAT; j++) begin
        slots[j] <= '0;
      end
      rr_ptr <= '0;
    end else begin
      // Advance time by one cycle; flush drops everything not yet on the CDB.
      for (int j = 0; j < MAX_LAT - 1; j++) begin
        slots[j] <= bus.flush ? '0 : slots[j+1];
      end
      slots[MAX_LAT-1] <= '0;
      // A grant at latency L lands at now+L, i.e. index L-1 after the shift.
      for (int k = 0; k < NUM_RS; k++) begin
        if (grant[k]) begin
          slots[int'(RS_LAT[k*LAT_W +: LAT_W]) - 1] <= '{
            valid: 1'b1,
            tag:   bus.rs_dst_tag[k*ROB_TAG_LEN +: ROB_TAG_LEN],
            src:   SLOT_SRC_W'(k)
          };
        end
      end
      rr_ptr <= next_ptr;
    end
  end

  assign bus.cdb_valid = slots[0].valid;
  assign bus.cdb_tag   = slots[0].tag;
  assign bus.cdb_src   = RS_IDX_W'(slots[0].src);

`ifdef ISSUE_SCHED_PERF_EN
  // Cycles where some requester wanted to issue but was held off; flush
  // cycles are excluded since nothing may issue then by design.
  logic stall_evt;
  assign stall_evt = (|(bus.rs_ready & ~grant)) && !bus.flush;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      perf_stall_cnt <= '0;
    end else if (stall_evt && (perf_stall_cnt != '1)) begin
      perf_stall_cnt <= perf_stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_issue_scheduler.sv
module tb_issue_scheduler;
  import sys_defs::*;

  localparam int N  = 4;
  localparam int IW = 2;
  localparam int ML = 4;
  localparam int LW = 3;
  localparam int TW = ROB_TAG_LEN;
  localparam logic [N*LW-1:0] LATS = {3'd4, 3'd1, 3'd1, 3'd1};

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  issue_scheduler_if #(.NUM_RS(N), .RS_IDX_W(IW)) bus();
`ifdef ISSUE_SCHED_PERF_EN
  logic [31:0] perf_stall_cnt;
`endif

  issue_scheduler #(
    .NUM_RS(N), .RS_IDX_W(IW), .MAX_LAT(ML), .LAT_W(LW), .RS_LAT(LATS)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
`ifdef ISSUE_SCHED_PERF_EN
    ,
    .perf_stall_cnt (perf_stall_cnt)
`endif
  );

  // Reference model: broadcasts keyed by the absolute cycle they appear on the CDB.
  typedef struct { int tag; int src; } bcast_t;
  bcast_t  sched [int];
  int      cyc = 0;
  int      rr  = 0;
  longint  perf_exp = 0;

  int checks = 0;
  int failures = 0;

  logic [N-1:0]  obs_issue;
  logic          obs_cv;
  logic [TW-1:0] obs_tag;
  logic [IW-1:0] obs_src;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic int lat_of(input int k);
    logic [N*LW-1:0] v;
    v = LATS;
    return int'(v[k*LW +: LW]);
  endfunction

  function automatic logic [N*TW-1:0] tags4(input int t0, input int t1, input int t2, input int t3);
    return {TW'(t3), TW'(t2), TW'(t1), TW'(t0)};
  endfunction

  // One clock cycle: drive inputs just after posedge, compare at negedge,
  // then advance the model. Entry and exit are at posedge+1.
  task automatic step(input logic [N-1:0] rdy, input logic [N*TW-1:0] tags, input logic fl);
    logic [N-1:0] eg;
    bcast_t b;
    int last;
    int idx;
    int keys[$];
    bus.rs_ready   = rdy;
    bus.rs_dst_tag = tags;
    bus.flush      = fl;
    @(negedge clk);
    eg   = '0;
    last = -1;
    if (!fl) begin
      for (int i = 0; i < N; i++) begin
        idx = (rr + i) % N;
        if (rdy[idx] && !sched.exists(cyc + lat_of(idx))) begin
          eg[idx] = 1'b1;
          b.tag = int'(tags[idx*TW +: TW]);
          b.src = idx;
          sched[cyc + lat_of(idx)] = b;
          last = idx;
        end
      end
    end
    obs_issue = bus.rs_issue;
    obs_cv    = bus.cdb_valid;
    obs_tag   = bus.cdb_tag;
    obs_src   = bus.cdb_src;
    check_val("issue", 64'(obs_issue), 64'(eg));
    check_val("cdb_valid", 64'(obs_cv), 64'(sched.exists(cyc) ? 1 : 0));
    if (sched.exists(cyc)) begin
      check_val("cdb_tag", 64'(obs_tag), 64'(sched[cyc].tag));
      check_val("cdb_src", 64'(obs_src), 64'(sched[cyc].src));
    end
`ifdef ISSUE_SCHED_PERF_EN
    check_val("perf_stall_cnt", 64'(perf_stall_cnt), 64'(perf_exp));
`endif
    if (last >= 0) rr = (last + 1) % N;
    if (fl) begin
      foreach (sched[k]) if (k > cyc) keys.push_back(k);
      foreach (keys[i]) sched.delete(keys[i]);
    end
    if (sched.exists(cyc)) sched.delete(cyc);
    if (!fl && ((rdy & ~eg) != '0) && perf_exp < 64'hFFFF_FFFF) perf_exp++;
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic model_clear();
    sched.delete();
    rr = 0;
    perf_exp = 0;
  endtask

  task automatic reset_dut();
    reset_n = 1'b0;
    bus.rs_ready = '0;
    bus.flush = 1'b0;
    model_clear();
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
  endtask

  // Reset in the middle of traffic: outputs must drop at once, and the
  // first grant afterwards must start from RS0.
  task automatic mid_reset();
    bus.rs_ready   = N'($urandom_range(1, 15));
    bus.rs_dst_tag = (N*TW)'({$urandom(), $urandom()});
    bus.flush      = 1'b0;
    reset_n = 1'b0;
    #1;
    check_val("rst_issue", 64'(bus.rs_issue), 64'd0);
    check_val("rst_cdb_valid", 64'(bus.cdb_valid), 64'd0);
    check_val("rst_cdb_tag", 64'(bus.cdb_tag), 64'd0);
    check_val("rst_cdb_src", 64'(bus.cdb_src), 64'd0);
`ifdef ISSUE_SCHED_PERF_EN
    check_val("rst_perf", 64'(perf_stall_cnt), 64'd0);
`endif
    model_clear();
    @(posedge clk);
    #1 reset_n = 1'b1;
    step(4'b0011, (N*TW)'({$urandom(), $urandom()}), 1'b0);
    check_val("rst_first_rs0", 64'(obs_issue), 64'b0001);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1);
  end

  initial begin
    bus.rs_ready   = '0;
    bus.rs_dst_tag = '0;
    bus.flush      = 1'b0;
    #2;
    check_val("init_issue", 64'(bus.rs_issue), 64'd0);
    check_val("init_cdb_valid", 64'(bus.cdb_valid), 64'd0);
    check_val("init_cdb_tag", 64'(bus.cdb_tag), 64'd0);
    check_val("init_cdb_src", 64'(bus.cdb_src), 64'd0);
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;

    // Single latency-1 issue.
    reset_dut();
    step(4'b0001, tags4(5, 0, 0, 0), 1'b0);
    check_val("alu_issue", 64'(obs_issue), 64'b0001);
    step(4'b0000, '0, 1'b0);
    check_val("alu_cv", 64'(obs_cv), 64'd1);
    check_val("alu_tag", 64'(obs_tag), 64'd5);
    check_val("alu_src", 64'(obs_src), 64'd0);

    // Three latency-1 stations contending for the same CDB cycle.
    reset_dut();
    for (int c = 1; c <= 3; c++) begin
      step(4'b0111, tags4(1, 2, 3, 0), 1'b0);
      check_val("cont_issue", 64'(obs_issue), 64'(1 << (c - 1)));
      if (c > 1) check_val("cont_tag", 64'(obs_tag), 64'(c - 1));
    end
    step(4'b0000, '0, 1'b0);
    check_val("cont_last_cv", 64'(obs_cv), 64'd1);
    check_val("cont_last_tag", 64'(obs_tag), 64'd3);

    // Latency-4 reservation blocks a later latency-1 request for one cycle.
    reset_dut();
    step(4'b1000, tags4(0, 0, 0, 9), 1'b0);
    check_val("coll_rs3_issue", 64'(obs_issue), 64'b1000);
    step(4'b0000, '0, 1'b0);
    step(4'b0000, '0, 1'b0);
    step(4'b0001, tags4(7, 0, 0, 0), 1'b0);
    check_val("coll_blocked", 64'(obs_issue), 64'd0);
    step(4'b0001, tags4(7, 0, 0, 0), 1'b0);
    check_val("coll_granted", 64'(obs_issue), 64'b0001);
    check_val("coll_tag9", 64'(obs_tag), 64'd9);
    check_val("coll_src3", 64'(obs_src), 64'd3);
    step(4'b0000, '0, 1'b0);
    check_val("coll_cv7", 64'(obs_cv), 64'd1);
    check_val("coll_tag7", 64'(obs_tag), 64'd7);
    check_val("coll_src0", 64'(obs_src), 64'd0);

    // Two grants in one cycle at different latencies.
    reset_dut();
    step(4'b1001, tags4(4, 0, 0, 8), 1'b0);
    check_val("dual_issue", 64'(obs_issue), 64'b1001);
    step(4'b0000, '0, 1'b0);
    check_val("dual_c2_tag", 64'(obs_tag), 64'd4);
    step(4'b0000, '0, 1'b0);
    check_val("dual_c3_cv", 64'(obs_cv), 64'd0);
    step(4'b0000, '0, 1'b0);
    check_val("dual_c4_cv", 64'(obs_cv), 64'd0);
    step(4'b0000, '0, 1'b0);
    check_val("dual_c5_cv", 64'(obs_cv), 64'd1);
    check_val("dual_c5_tag", 64'(obs_tag), 64'd8);
    check_val("dual_c5_src", 64'(obs_src), 64'd3);

    // Flush squashes an in-flight latency-4 broadcast.
    reset_dut();
    step(4'b1000, tags4(0, 0, 0, 9), 1'b0);
    check_val("flush_c1_issue", 64'(obs_issue), 64'b1000);
    step(4'b1000, tags4(0, 0, 0, 9), 1'b1);
    check_val("flush_c2_issue", 64'(obs_issue), 64'd0);
    for (int c = 3; c <= 5; c++) begin
      step(4'b0000, '0, 1'b0);
      check_val("flush_cv_low", 64'(obs_cv), 64'd0);
    end

    // Randomised traffic with occasional flush and mid-traffic reset.
    reset_dut();
    for (int it = 0; it < 800; it++) begin
      if ($urandom_range(0, 79) == 0) begin
        mid_reset();
      end else begin
        step(N'($urandom_range(0, 15)),
             (N*TW)'({$urandom(), $urandom()}),
             ($urandom_range(0, 19) == 0));
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
